// File: rtl/m3_pkg.sv
// Shared definitions for the three-phase gate PWM: phase states, defaults and sector table.
package m3_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned DEAD_CYC_DEF = 8;
  localparam int unsigned STEP_W       = 4;
  localparam int unsigned DEAD_W       = 8;
  localparam int unsigned NUM_PHASES   = 3;

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_DEAD = 2'd1,
    PH_HI   = 2'd2,
    PH_LO   = 2'd3
  } phaseState_t;

  typedef enum logic [1:0] {
    ROLE_FLOAT = 2'd0,
    ROLE_HIGH  = 2'd1,
    ROLE_LOW   = 2'd2
  } phaseRole_t;

  // Role of a phase (0=U, 1=V, 2=W) in a commutation sector.
  function automatic phaseRole_t sectorRole(input logic [2:0] sector, input logic [1:0] phase);
    logic [1:0] hiPh;
    logic [1:0] loPh;
    phaseRole_t role;
    case (sector)
      3'd0:    begin hiPh = 2'd0; loPh = 2'd1; end
      3'd1:    begin hiPh = 2'd0; loPh = 2'd2; end
      3'd2:    begin hiPh = 2'd1; loPh = 2'd2; end
      3'd3:    begin hiPh = 2'd1; loPh = 2'd0; end
      3'd4:    begin hiPh = 2'd2; loPh = 2'd0; end
      3'd5:    begin hiPh = 2'd2; loPh = 2'd1; end
      default: begin hiPh = 2'd3; loPh = 2'd3; end
    endcase
    role = ROLE_FLOAT;
    if (phase == hiPh) begin
      role = ROLE_HIGH;
    end else if (phase == loPh) begin
      role = ROLE_LOW;
    end
    return role;
  endfunction

endpackage

// File: rtl/m3_phase_dead_time.sv
// Per-phase gate sequencer: enforces a dead interval before any gate turns on.
module m3_phase_dead_time
  import m3_pkg::*;
#(
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic        clkI,
  input  logic        nRstI,
  input  phaseState_t reqI,
  output logic        hiO,
  output logic        loO
);

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

  phaseState_t       state;
  phaseState_t       target;
  logic [DEAD_W-1:0] deadCnt;

  // Gates are decoded from the next state so they change together with it.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state   <= PH_OFF;
      target  <= PH_OFF;
      deadCnt <= '0;
      hiO     <= 1'b0;
      loO     <= 1'b0;
    end else begin
      hiO <= 1'b0;
      loO <= 1'b0;
      if (reqI == PH_OFF) begin
        state <= PH_OFF;
      end else if (state == PH_DEAD) begin
        if (reqI != target) begin
          target  <= reqI;
          deadCnt <= DEAD_LOAD;
        end else if (deadCnt == '0) begin
          state <= target;
          hiO   <= (target == PH_HI);
          loO   <= (target == PH_LO);
        end else begin
          deadCnt <= deadCnt - DEAD_W'(1);
        end
      end else if (reqI != state) begin
        state   <= PH_DEAD;
        target  <= reqI;
        deadCnt <= DEAD_LOAD;
      end else begin
        hiO <= (state == PH_HI);
        loO <= (state == PH_LO);
      end
    end
  end

endmodule

// File: rtl/m3_phase_gate_pwm.sv
// Six-step commutation gate driver with PWM on the high side and per-phase dead time.
module m3_phase_gate_pwm
  import m3_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic [STEP_W-1:0]   stepI,
  input  logic                stepStrobeI,
  input  logic [PWM_BITS-1:0] powerI,
  input  logic                invRotateI,
  input  logic                enableI,
  input  logic                forceStopI,
  output logic                uHiO,
  output logic                uLoO,
  output logic                vHiO,
  output logic                vLoO,
  output logic                wHiO,
  output logic                wLoO,
  output logic                faultO,
  output logic                pwmWrapO
);

  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [STEP_W-1:0]   STEP_MAX = STEP_W'(12);

  logic [PWM_BITS-1:0]   cnt;
  logic [PWM_BITS-1:0]   dutyReg;
  logic [STEP_W-1:0]     stepReg;
  logic                  pwmOn;
  logic                  driveOk;
  logic [2:0]            sectorRaw;
  logic [2:0]            sector;
  phaseState_t           phaseReq [NUM_PHASES];
  logic [NUM_PHASES-1:0] hiGate;
  logic [NUM_PHASES-1:0] loGate;

  // Free-running carrier; duty is latched at the top so it applies from count 0.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cnt      <= '0;
      dutyReg  <= '0;
      pwmWrapO <= 1'b0;
    end else begin
      cnt      <= cnt + PWM_BITS'(1);
      pwmWrapO <= (cnt == CNT_MAX);
      if (cnt == CNT_MAX) begin
        dutyReg <= powerI;
      end
    end
  end

  // Step capture; disable beats stop beats strobe.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      stepReg <= '0;
      faultO  <= 1'b0;
    end else if (!enableI) begin
      stepReg <= '0;
      faultO  <= 1'b0;
    end else if (forceStopI) begin
      stepReg <= '0;
    end else if (stepStrobeI) begin
      if (stepI > STEP_MAX) begin
        stepReg <= '0;
        faultO  <= 1'b1;
      end else begin
        stepReg <= stepI;
      end
    end
  end

  assign pwmOn     = (cnt < dutyReg);
  assign driveOk   = enableI && !forceStopI && (stepReg != '0);
  assign sectorRaw = 3'((stepReg - STEP_W'(1)) >> 1);
  assign sector    = invRotateI ? 3'(3'd5 - sectorRaw) : sectorRaw;

  // Stop/disable request OFF directly so every phase drops on the next edge.
  always_comb begin
    for (int p = 0; p < int'(NUM_PHASES); p++) begin
      phaseReq[p] = PH_OFF;
      if (driveOk) begin
        case (sectorRole(sector, 2'(p)))
          ROLE_HIGH: phaseReq[p] = pwmOn ? PH_HI : PH_OFF;
          ROLE_LOW:  phaseReq[p] = PH_LO;
          default:   phaseReq[p] = PH_OFF;
        endcase
      end
    end
  end

  for (genvar p = 0; p < int'(NUM_PHASES); p++) begin : gPhase
    m3_phase_dead_time #(
      .DEAD_CYC(DEAD_CYC)
    ) uPhase (
      .clkI (clkI),
      .nRstI(nRstI),
      .reqI (phaseReq[p]),
      .hiO  (hiGate[p]),
      .loO  (loGate[p])
    );
  end

  assign uHiO = hiGate[0];
  assign uLoO = loGate[0];
  assign vHiO = hiGate[1];
  assign vLoO = loGate[1];
  assign wHiO = hiGate[2];
  assign wLoO = loGate[2];

endmodule

// File: tb/tb_m3_phase_gate_pwm.sv
// Randomized bench for m3_phase_gate_pwm against a request-history reference model.
module tb_m3_phase_gate_pwm;

  localparam int D = 8;
  localparam int R_OFF = 0;
  localparam int R_HI = 1;
  localparam int R_LO = 2;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic [3:0] stepIn = '0;
  logic       strobe = 1'b0;
  logic [7:0] power = '0;
  logic       invRot = 1'b0;
  logic       enable = 1'b1;
  logic       forceStop = 1'b0;
  logic       uHi, uLo, vHi, vLo, wHi, wLo, fault, pwmWrap;

  int compared = 0;
  int mismatched = 0;
  bit checkOn = 1'b0;

  // Model state: a gate is on once its request has been steady for D+1 cycles.
  int hiPh[6] = '{0, 0, 1, 1, 2, 2};
  int loPh[6] = '{1, 2, 2, 0, 0, 1};
  int mCnt = 0, mDuty = 0, mStep = 0;
  bit mFault = 1'b0, mWrap = 1'b0;
  int lastReq[3];
  int run[3];
  bit expHi[3];
  bit expLo[3];

  m3_phase_gate_pwm dut (
    .clkI(clk), .nRstI(nRst), .stepI(stepIn), .stepStrobeI(strobe), .powerI(power),
    .invRotateI(invRot), .enableI(enable), .forceStopI(forceStop),
    .uHiO(uHi), .uLoO(uLo), .vHiO(vHi), .vLoO(vLo), .wHiO(wHi), .wLoO(wLo),
    .faultO(fault), .pwmWrapO(pwmWrap)
  );

  always #5 clk = ~clk;

  function automatic int reqFor(int p);
    int sec;
    if (!(enable && !forceStop && mStep != 0)) return R_OFF;
    sec = (mStep - 1) / 2;
    if (invRot) sec = 5 - sec;
    if (p == hiPh[sec]) return (mCnt < mDuty) ? R_HI : R_OFF;
    if (p == loPh[sec]) return R_LO;
    return R_OFF;
  endfunction

  function automatic int runAfter(int p);
    return (reqFor(p) == lastReq[p]) ? run[p] + 1 : 1;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mCnt <= 0; mDuty <= 0; mStep <= 0; mFault <= 1'b0; mWrap <= 1'b0;
      for (int p = 0; p < 3; p++) begin
        lastReq[p] <= R_OFF; run[p] <= 0; expHi[p] <= 1'b0; expLo[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        lastReq[p] <= reqFor(p);
        run[p]     <= runAfter(p);
        expHi[p]   <= (reqFor(p) == R_HI) && (runAfter(p) > D);
        expLo[p]   <= (reqFor(p) == R_LO) && (runAfter(p) > D);
      end
      mWrap <= (mCnt == 255);
      mCnt  <= (mCnt + 1) % 256;
      if (mCnt == 255) mDuty <= int'(power);
      if (!enable) begin
        mStep <= 0; mFault <= 1'b0;
      end else if (forceStop) begin
        mStep <= 0;
      end else if (strobe) begin
        if (stepIn > 4'd12) begin
          mStep <= 0; mFault <= 1'b1;
        end else begin
          mStep <= int'(stepIn);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      chk("uHi", int'(uHi), int'(expHi[0]));
      chk("uLo", int'(uLo), int'(expLo[0]));
      chk("vHi", int'(vHi), int'(expHi[1]));
      chk("vLo", int'(vLo), int'(expLo[1]));
      chk("wHi", int'(wHi), int'(expHi[2]));
      chk("wLo", int'(wLo), int'(expLo[2]));
      chk("fault", int'(fault), int'(mFault));
      chk("wrap", int'(pwmWrap), int'(mWrap));
      chk("shootU", int'(uHi & uLo), 0);
      chk("shootV", int'(vHi & vLo), 0);
      chk("shootW", int'(wHi & wLo), 0);
    end
  end

  task automatic gatesOff(input string name);
    chk(name, int'({uHi, uLo, vHi, vLo, wHi, wLo}), 0);
  endtask

  task automatic waitWrap();
    int k = 0;
    while (!pwmWrap && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wrapSeen", int'(pwmWrap), 1);
  endtask

  task automatic countWindow(input int changeAt, input int newPower, input int expN, input string name);
    int n = 0;
    waitWrap();
    for (int i = 0; i < 256; i++) begin
      n += int'(uHi);
      if (i == changeAt) power = 8'(newPower);
      @(negedge clk);
    end
    chk(name, n, expN);
  endtask

  task automatic strobeStep(input int s);
    stepIn = 4'(s);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin
    int last;
    int nWrap;
    #1 nRst = 1'b0;
    repeat (3) @(negedge clk);
    gatesOff("rstGates");
    chk("rstFault", int'(fault), 0);
    chk("rstWrap", int'(pwmWrap), 0);
    nRst = 1'b1;
    checkOn = 1'b1;

    // Idle: wrap every 256 cycles, nothing driven.
    last = -1;
    nWrap = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (pwmWrap) begin
        if (last >= 0) chk("wrapPeriod", i - last, 256);
        last = i;
        nWrap++;
      end
    end
    chk("wrapCount", nWrap, 3);

    // Half duty, sector 0: low side on after dead time, high side windows.
    power = 8'd128;
    waitWrap();
    strobeStep(1);
    repeat (D) @(negedge clk);
    chk("vLoDead", int'(vLo), 0);
    @(negedge clk);
    chk("vLoOn", int'(vLo), 1);
    chk("wOff", int'({wHi, wLo}), 0);
    countWindow(-1, 0, 120, "duty128");
    countWindow(100, 64, 120, "duty128Hold");
    countWindow(-1, 0, 56, "duty64");
    countWindow(100, 200, 56, "duty64Hold");
    countWindow(100, 0, 192, "duty200");
    countWindow(100, 255, 0, "duty0");
    countWindow(-1, 0, 247, "duty255");

    // Asynchronous reset drops gates without waiting for a clock.
    #3 nRst = 1'b0;
    #1 gatesOff("asyncRst");
    @(negedge clk);
    nRst = 1'b1;
    power = 8'd128;

    // Force stop while LO active, with a coincident strobe.
    strobeStep(1);
    repeat (20) @(negedge clk);
    chk("vLoActive", int'(vLo), 1);
    forceStop = 1'b1;
    stepIn = 4'd3;
    strobe = 1'b1;
    @(negedge clk);
    forceStop = 1'b0;
    strobe = 1'b0;
    gatesOff("stopLo");
    repeat (20) @(negedge clk);
    gatesOff("stopStrobeIgnored");

    // Force stop during dead time.
    strobeStep(1);
    @(negedge clk);
    forceStop = 1'b1;
    @(negedge clk);
    forceStop = 1'b0;
    gatesOff("stopDead");
    repeat (D + 3) @(negedge clk);
    gatesOff("stopDeadHeld");

    // Illegal step sets fault; one cycle of disable clears it.
    strobeStep(1);
    repeat (20) @(negedge clk);
    strobeStep(14);
    chk("faultSet", int'(fault), 1);
    @(negedge clk);
    gatesOff("faultGates");
    repeat (5) @(negedge clk);
    chk("faultSticky", int'(fault), 1);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk("faultClr", int'(fault), 0);

    // Full step sequence, forward then reversed.
    for (int inv = 0; inv < 2; inv++) begin
      invRot = 1'(inv);
      for (int s = 1; s <= 12; s++) begin
        strobeStep(s);
        repeat (30) @(negedge clk);
      end
    end
    invRot = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 20000; c++) begin
      strobe = ($urandom_range(0, 24) == 0);
      if (strobe)
        stepIn = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0:       power = 8'd0;
          1:       power = 8'd255;
          default: power = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 999) == 0) invRot = ~invRot;
      enable = ($urandom_range(0, 599) != 0);
      forceStop = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    strobe = 1'b0;
    enable = 1'b1;
    forceStop = 1'b0;
    repeat (5) @(negedge clk);
    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
